// File: rtl/dmi_jtag_access.sv
// rtl/dmi_jtag_access.sv - JTAG-side DMI access controller between the TAP DMI register and dtm_cdc
module dmi_jtag_access #(
    parameter int unsigned ABITS = 7,
    parameter int unsigned DBITS = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   capture_i,
    input  logic                   update_i,
    input  logic [ABITS+DBITS+1:0] dr_i,
    output logic [ABITS+DBITS+1:0] dr_o,
    input  logic                   dmireset_i,
    input  logic                   dmihardreset_i,
    output logic [1:0]             dmistat_o,
    output logic                   dmi_clear_o,
    output logic [ABITS+DBITS+1:0] dmi_req_o,
    output logic                   dmi_req_valid_o,
    input  logic                   dmi_req_ready_i,
    input  logic [DBITS+1:0]       dmi_resp_i,
    input  logic                   dmi_resp_valid_i,
    output logic                   dmi_resp_ready_o
);

    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] STAT_OK   = 2'd0;
    localparam logic [1:0] STAT_BUSY = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [ABITS-1:0]       r_addr;
    logic [ABITS-1:0]       w_addr_nxt;
    logic [DBITS-1:0]       r_data;
    logic [DBITS-1:0]       w_data_nxt;
    logic [1:0]             r_op;
    logic [1:0]             w_op_nxt;
    logic [1:0]             r_error;
    logic [1:0]             w_error_nxt;
    logic [ABITS+DBITS+1:0] r_dr;
    logic [ABITS+DBITS+1:0] w_dr_nxt;
    logic                   r_clear;
    logic                   w_clear_nxt;

    // Field views of the shifted-in DR and of the response
    logic [ABITS-1:0] w_upd_addr;
    logic [DBITS-1:0] w_upd_data;
    logic [1:0]       w_upd_op;
    logic [DBITS-1:0] w_resp_data;
    logic [1:0]       w_resp_code;
    logic             w_busy;
    logic [1:0]       w_err_eff;
    logic [1:0]       w_status;

    assign w_upd_addr  = dr_i[ABITS+DBITS+1:DBITS+2];
    assign w_upd_data  = dr_i[DBITS+1:2];
    assign w_upd_op    = dr_i[1:0];
    assign w_resp_data = dmi_resp_i[DBITS+1:2];
    assign w_resp_code = dmi_resp_i[1:0];
    assign w_busy      = (r_state != ST_IDLE);

    // A dmireset in the same cycle already counts as cleared for update/capture decisions
    assign w_err_eff   = dmireset_i ? STAT_OK : r_error;
    assign w_status    = (w_err_eff != STAT_OK) ? w_err_eff : (w_busy ? STAT_BUSY : STAT_OK);

    assign dr_o        = r_dr;
    assign dmistat_o   = r_error;
    assign dmi_clear_o = r_clear;
    assign dmi_req_o   = {r_addr, r_op, r_data};

    // State and data registers, all cleared asynchronously by trst_n
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_op    <= '0;
            r_error <= '0;
            r_dr    <= '0;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_op    <= w_op_nxt;
            r_error <= w_error_nxt;
            r_dr    <= w_dr_nxt;
            r_clear <= w_clear_nxt;
        end
    end

    // Next-state, handshake outputs and sticky-error update in priority order
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_op_nxt         = r_op;
        w_error_nxt      = r_error;
        w_dr_nxt         = r_dr;
        w_clear_nxt      = 1'b0;
        dmi_req_valid_o  = (r_state == ST_REQ);
        dmi_resp_ready_o = (r_state == ST_WAIT);

        if (dmihardreset_i) begin
            // Abort: anything in flight is dropped and dtm_cdc is told to flush
            w_state_nxt = ST_IDLE;
            w_error_nxt = STAT_OK;
            w_clear_nxt = 1'b1;
        end else begin
            if (capture_i) begin
                w_dr_nxt = {r_addr, r_data, w_status};
            end

            case (r_state)
                ST_IDLE: begin
                    if (update_i && (w_err_eff == STAT_OK) &&
                        ((w_upd_op == OP_READ) || (w_upd_op == OP_WRITE))) begin
                        w_addr_nxt  = w_upd_addr;
                        w_data_nxt  = w_upd_data;
                        w_op_nxt    = w_upd_op;
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmi_req_ready_i) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmi_resp_valid_i) begin
                        w_state_nxt = ST_IDLE;
                        if (r_op == OP_READ) begin
                            w_data_nxt = w_resp_data;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            // The first error reported sticks until dmireset or dmihardreset
            if (dmireset_i) begin
                w_error_nxt = STAT_OK;
            end else if (w_busy && (update_i || capture_i) && (r_error == STAT_OK)) begin
                w_error_nxt = STAT_BUSY;
            end else if ((r_state == ST_WAIT) && dmi_resp_valid_i &&
                         (w_resp_code != STAT_OK) && (r_error == STAT_OK)) begin
                w_error_nxt = w_resp_code;
            end
        end
    end

endmodule

// File: tb/tb_dmi_jtag_access.sv
// tb/tb_dmi_jtag_access.sv - self-checking bench for dmi_jtag_access
module tb_dmi_jtag_access;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        capture_i;
    logic        update_i;
    logic [40:0] dr_i;
    logic [40:0] dr_o;
    logic        dmireset_i;
    logic        dmihardreset_i;
    logic [1:0]  dmistat_o;
    logic        dmi_clear_o;
    logic [40:0] dmi_req_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [33:0] dmi_resp_i;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    dmi_jtag_access #(.ABITS(7), .DBITS(32)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .capture_i        (capture_i),
        .update_i         (update_i),
        .dr_i             (dr_i),
        .dr_o             (dr_o),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .dmistat_o        (dmistat_o),
        .dmi_clear_o      (dmi_clear_o),
        .dmi_req_o        (dmi_req_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, split into "offered" and "handed over"
    bit          m_pending = 1'b0;
    bit          m_handed  = 1'b0;
    logic [6:0]  m_addr    = '0;
    logic [31:0] m_data    = '0;
    logic [1:0]  m_op      = '0;
    logic [1:0]  m_err     = '0;
    logic [40:0] m_dr      = '0;
    bit          m_clear   = 1'b0;
    logic [1:0]  m_seen;
    logic [1:0]  m_nerr;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_pending = 1'b0;
            m_handed  = 1'b0;
            m_addr    = '0;
            m_data    = '0;
            m_op      = '0;
            m_err     = '0;
            m_dr      = '0;
            m_clear   = 1'b0;
        end else begin
            m_clear = dmihardreset_i;
            if (dmihardreset_i) begin
                m_pending = 1'b0;
                m_handed  = 1'b0;
                m_err     = 2'd0;
            end else begin
                m_seen = dmireset_i ? 2'd0 : m_err;
                if (capture_i)
                    m_dr = {m_addr, m_data, (m_seen != 0) ? m_seen : (m_pending ? 2'd3 : 2'd0)};
                m_nerr = m_err;
                if (dmireset_i)
                    m_nerr = 2'd0;
                else if (m_err == 0 && m_pending && (update_i || capture_i))
                    m_nerr = 2'd3;
                else if (m_err == 0 && m_pending && m_handed && dmi_resp_valid_i && dmi_resp_i[1:0] != 0)
                    m_nerr = dmi_resp_i[1:0];
                if (m_pending && !m_handed) begin
                    if (dmi_req_ready_i) m_handed = 1'b1;
                end else if (m_pending && m_handed) begin
                    if (dmi_resp_valid_i) begin
                        if (m_op == 2'd1) m_data = dmi_resp_i[33:2];
                        m_pending = 1'b0;
                        m_handed  = 1'b0;
                    end
                end else if (update_i && m_seen == 0 && (dr_i[1:0] == 2'd1 || dr_i[1:0] == 2'd2)) begin
                    m_addr    = dr_i[40:34];
                    m_data    = dr_i[33:2];
                    m_op      = dr_i[1:0];
                    m_pending = 1'b1;
                end
                m_err = m_nerr;
            end
        end
    end

    // Compare every DUT output against the model on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dr_o",       64'(dr_o),             64'(m_dr));
            chk("dmistat",    64'(dmistat_o),        64'(m_err));
            chk("dmi_clear",  64'(dmi_clear_o),      64'(m_clear));
            chk("req_valid",  64'(dmi_req_valid_o),  64'(m_pending && !m_handed));
            chk("resp_ready", 64'(dmi_resp_ready_o), 64'(m_pending && m_handed));
            if (m_pending)
                chk("req_payload", 64'(dmi_req_o), 64'({m_addr, m_op, m_data}));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        update_i         = 1'b0;
        capture_i        = 1'b0;
        dmireset_i       = 1'b0;
        dmihardreset_i   = 1'b0;
        dmi_resp_valid_i = 1'b0;
    endtask

    task automatic upd(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        dr_i     = {a, d, op};
        update_i = 1'b1;
        tick();
    endtask

    task automatic resp(input logic [31:0] d, input logic [1:0] code);
        dmi_resp_i       = {d, code};
        dmi_resp_valid_i = 1'b1;
        tick();
    endtask

    initial begin
        rst_ni           = 1'b0;
        capture_i        = 1'b0;
        update_i         = 1'b0;
        dr_i             = '0;
        dmireset_i       = 1'b0;
        dmihardreset_i   = 1'b0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = '0;
        dmi_resp_valid_i = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) tick();
        chk("rst_dr_o", 64'(dr_o), 64'd0);
        chk("rst_dmistat", 64'(dmistat_o), 64'd0);
        chk("rst_valid", 64'(dmi_req_valid_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Write
        upd(7'h10, 32'hDEADBEEF, 2'd2);
        chk("wr_valid", 64'(dmi_req_valid_o), 64'd1);
        chk("wr_req", 64'(dmi_req_o), 64'({7'h10, 2'd2, 32'hDEADBEEF}));
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        chk("wr_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        resp(32'h0, 2'd0);
        capture_i = 1'b1;
        tick();
        chk("wr_capture", 64'(dr_o), 64'({7'h10, 32'hDEADBEEF, 2'd0}));

        // Read
        upd(7'h11, 32'h0, 2'd1);
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        resp(32'h12345678, 2'd0);
        capture_i = 1'b1;
        tick();
        chk("rd_capture", 64'(dr_o), 64'({7'h11, 32'h12345678, 2'd0}));
        chk("rd_dmistat", 64'(dmistat_o), 64'd0);

        // Busy
        upd(7'h20, 32'h55, 2'd2);
        capture_i = 1'b1;
        tick();
        chk("busy_status", 64'(dr_o[1:0]), 64'd3);
        chk("busy_dmistat", 64'(dmistat_o), 64'd3);
        upd(7'h21, 32'h66, 2'd2);
        chk("busy_ignored", 64'(dmi_req_o), 64'({7'h20, 2'd2, 32'h55}));
        dmireset_i = 1'b1;
        tick();
        chk("busy_cleared", 64'(dmistat_o), 64'd0);
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        resp(32'h0, 2'd0);

        // Failed read, sticky error
        upd(7'h30, 32'h0, 2'd1);
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        resp(32'h0000AAAA, 2'd2);
        chk("fail_dmistat", 64'(dmistat_o), 64'd2);
        upd(7'h31, 32'h0, 2'd2);
        chk("fail_upd_ignored", 64'(dmi_req_valid_o), 64'd0);
        capture_i = 1'b1;
        tick();
        chk("fail_capture", 64'(dr_o), 64'({7'h30, 32'h0000AAAA, 2'd2}));
        dmireset_i = 1'b1;
        tick();
        upd(7'h32, 32'h0, 2'd1);
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        capture_i = 1'b1;
        tick();
        resp(32'h0, 2'd2);
        chk("sticky_kept", 64'(dmistat_o), 64'd3);
        dmireset_i = 1'b1;
        tick();

        // Hardreset mid-WAIT
        upd(7'h40, 32'hCAFE0000, 2'd1);
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        chk("hr_in_wait", 64'(dmi_resp_ready_o), 64'd1);
        dmihardreset_i = 1'b1;
        tick();
        chk("hr_clear", 64'(dmi_clear_o), 64'd1);
        chk("hr_valid", 64'(dmi_req_valid_o), 64'd0);
        chk("hr_ready", 64'(dmi_resp_ready_o), 64'd0);
        chk("hr_dmistat", 64'(dmistat_o), 64'd0);
        tick();
        chk("hr_clear_pulse", 64'(dmi_clear_o), 64'd0);
        dmi_resp_i       = {32'h11111111, 2'd0};
        dmi_resp_valid_i = 1'b1;
        #1;
        chk("hr_late_ready", 64'(dmi_resp_ready_o), 64'd0);
        tick();
        capture_i = 1'b1;
        tick();
        chk("hr_capture", 64'(dr_o), 64'({7'h40, 32'hCAFE0000, 2'd0}));

        // Asynchronous reset mid-REQ
        upd(7'h50, 32'h1, 2'd2);
        chk("ar_valid_before", 64'(dmi_req_valid_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_valid", 64'(dmi_req_valid_o), 64'd0);
        chk("ar_dr_o", 64'(dr_o), 64'd0);
        chk("ar_dmistat", 64'(dmistat_o), 64'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            int c;
            r = $urandom_range(0, 9);
            update_i  = (r < 2);
            capture_i = (r == 2);
            dr_i      = {7'($urandom), 32'($urandom), 2'($urandom)};
            dmireset_i       = ($urandom_range(0, 15) == 0);
            dmihardreset_i   = ($urandom_range(0, 47) == 0);
            dmi_req_ready_i  = 1'($urandom_range(0, 1));
            dmi_resp_valid_i = ($urandom_range(0, 2) == 0);
            c = $urandom_range(0, 7);
            dmi_resp_i = {32'($urandom), (c < 5) ? 2'd0 : (c == 5) ? 2'd2 : (c == 6) ? 2'd3 : 2'd1};
            @(posedge clk);
            #1;
        end
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
